// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Walks the channels selected in chan_mask from lowest to highest. For each
// channel it drives the ADC mux, waits a programmable settling time, takes
// 2^AVG_LOG2 conversions, and emits the truncated average. It keeps scanning
// while enable stays high. A conversion that never completes within TIMEOUT
// cycles sets a sticky error flag, and that channel is skipped.
//
// Ports
//   clk_clk          rising-edge clock
//   reset_reset_n    asynchronous active-low reset
//   enable           run continuous scans while high
//   chan_mask        channels to scan (bit i = channel i)
//   settle_cycles    mux settling delay in cycles
//   err_clr          clears timeout_err
//   adc_sel_channel  ADC mux select
//   adc_conv_start   one-cycle conversion start pulse
//   adc_conv_done    conversion complete, adc_data valid in the same cycle
//   adc_data         12-bit ADC sample
//   result_valid     one-cycle pulse qualifying result_channel/result_data
//   result_channel   channel of the last emitted result
//   result_data      averaged sample of the last emitted result
//   scan_done        pulses with the final channel of every scan
//   busy             high whenever the sequencer is not idle
//   timeout_err      sticky conversion-timeout flag
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic [7:0]  settle_cycles,
    input  logic        err_clr,
    output logic [2:0]  adc_sel_channel,
    output logic        adc_conv_start,
    input  logic        adc_conv_done,
    input  logic [11:0] adc_data,
    output logic        result_valid,
    output logic [2:0]  result_channel,
    output logic [11:0] result_data,
    output logic        scan_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SMP_W-1:0] LAST_SAMPLE = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD    = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        START,
        WAIT,
        ACCUM,
        EMIT,
        NEXT
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [7:0]         mask_q;
    logic [7:0]         settle_q;
    logic [7:0]         settle_cnt;
    logic [2:0]         cur_ch;
    logic [ACC_W-1:0]   acc;
    logic [SMP_W-1:0]   sample_cnt;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [7:0]         above_mask;
    logic               has_next;
    logic               last_sample;
    logic               tmo_hit;
    logic               scan_start;

    // Index of the lowest set bit; callers only use it on a non-zero mask.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Channels of the latched mask strictly above the current one decide
    // whether the scan continues or the current channel is the last.
    assign above_mask  = mask_q & (8'hFE << cur_ch);
    assign has_next    = |above_mask;
    assign last_sample = (sample_cnt == LAST_SAMPLE);
    assign scan_start  = enable && (chan_mask != 8'h00);

    // A timeout fires on the final WAIT cycle only when no conversion completes in it.
    assign tmo_hit     = (state == WAIT) && !adc_conv_done && (tmo_cnt == '0);

    // The mux select follows the channel register, so it is held stable
    // through settling and every conversion of that channel.
    assign adc_sel_channel = cur_ch;

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the pulse/status outputs. Deriving these from the
    // state register makes reset force them low immediately.
    always_comb begin
        next_state     = state;
        busy           = 1'b1;
        adc_conv_start = 1'b0;
        result_valid   = 1'b0;
        scan_done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (scan_start) begin
                    next_state = SELECT;
                end
            end
            SELECT: begin
                next_state = (settle_q == 8'd0) ? START : SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    next_state = START;
                end
            end
            START: begin
                adc_conv_start = 1'b1;
                next_state     = WAIT;
            end
            WAIT: begin
                if (adc_conv_done) begin
                    next_state = ACCUM;
                end else if (tmo_cnt == '0) begin
                    next_state = NEXT;
                    scan_done  = !has_next;
                end
            end
            ACCUM: begin
                next_state = last_sample ? EMIT : START;
            end
            EMIT: begin
                result_valid = 1'b1;
                scan_done    = !has_next;
                next_state   = NEXT;
            end
            NEXT: begin
                next_state = (has_next || scan_start) ? SELECT : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: scan latching, settle/timeout/sample counters, accumulator
    // and the result registers. The result is loaded on leaving ACCUM so it
    // is already stable while result_valid pulses in EMIT.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q         <= '0;
            settle_q       <= '0;
            settle_cnt     <= '0;
            cur_ch         <= '0;
            acc            <= '0;
            sample_cnt     <= '0;
            tmo_cnt        <= '0;
            result_channel <= '0;
            result_data    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            // A new timeout takes priority over a simultaneous clear.
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE, NEXT: begin
                    if ((state == NEXT) && has_next) begin
                        cur_ch     <= lowest_set(above_mask);
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else if (scan_start) begin
                        mask_q     <= chan_mask;
                        settle_q   <= settle_cycles;
                        cur_ch     <= lowest_set(chan_mask);
                        acc        <= '0;
                        sample_cnt <= '0;
                    end
                end
                SELECT: begin
                    settle_cnt <= settle_q - 8'd1;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                end
                START: begin
                    tmo_cnt <= TMO_LOAD;
                end
                WAIT: begin
                    if (adc_conv_done) begin
                        acc <= acc + ACC_W'(adc_data);
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                ACCUM: begin
                    if (last_sample) begin
                        result_data    <= 12'(acc >> AVG_LOG2);
                        result_channel <= cur_ch;
                    end else begin
                        sample_cnt <= sample_cnt + SMP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Self-checking bench for adc_scan_sequencer. An ADC model answers
// conversion starts from a per-channel sample table. A monitor collects
// emitted results. A reference model derives the expected results of a scan
// from the mask and the sample table: per enabled, responsive channel in
// ascending order, the truncated mean of its four samples.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [7:0]  settle_cycles;
    logic        err_clr;
    logic [2:0]  adc_sel_channel;
    logic        adc_conv_start;
    logic        adc_conv_done;
    logic [11:0] adc_data;
    logic        result_valid;
    logic [2:0]  result_channel;
    logic [11:0] result_data;
    logic        scan_done;
    logic        busy;
    logic        timeout_err;

    adc_scan_sequencer #(
        .AVG_LOG2 (2),
        .TIMEOUT  (1024)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .enable          (enable),
        .chan_mask       (chan_mask),
        .settle_cycles   (settle_cycles),
        .err_clr         (err_clr),
        .adc_sel_channel (adc_sel_channel),
        .adc_conv_start  (adc_conv_start),
        .adc_conv_done   (adc_conv_done),
        .adc_data        (adc_data),
        .result_valid    (result_valid),
        .result_channel  (result_channel),
        .result_data     (result_data),
        .scan_done       (scan_done),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        sd;
    } res_t;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] settle;
        int         lat;
        logic [7:0] dead;
        int         exp_start;
        logic       exp_tmo;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // ADC model configuration (written only by the stimulus process)
    logic [11:0] adc_vals [8][4];
    logic [7:0]  dead_mask = 8'h00;
    int          adc_lat = 1;
    logic        inject_done = 1'b0;
    logic [11:0] inject_data = 12'h000;

    // ADC model state
    int          pend = 0;
    logic [11:0] pend_val = 12'h000;
    int          sample_idx [8];

    // Monitor state
    res_t res_q [$];
    int   done_cnt = 0;
    int   start_cnt = 0;
    int   busy_cycles = 0;

    // Reference model output
    res_t exp_q [$];

    // ADC model: answers a start adc_lat cycles later with the next sample of
    // the selected channel; channels in dead_mask never answer.
    always @(negedge clk_clk) begin
        adc_conv_done = 1'b0;
        if (!reset_reset_n || !busy) begin
            pend = 0;
            for (int c = 0; c < 8; c++) sample_idx[c] = 0;
        end
        if (inject_done) begin
            adc_conv_done = 1'b1;
            adc_data      = inject_data;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                adc_conv_done = 1'b1;
                adc_data      = pend_val;
            end
        end
        if (reset_reset_n && adc_conv_start && !dead_mask[adc_sel_channel]) begin
            pend     = adc_lat;
            pend_val = adc_vals[adc_sel_channel][sample_idx[adc_sel_channel] % 4];
            sample_idx[adc_sel_channel]++;
        end
    end

    // Monitor: records every emitted result and counts pulses.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if (result_valid) res_q.push_back('{result_channel, result_data, scan_done});
            if (scan_done) done_cnt++;
            if (adc_conv_start) start_cnt++;
            if (busy) busy_cycles++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected results of one scan from the sample table.
    function automatic void buildExpected(input logic [7:0] mask, input logic [7:0] dead);
        int last_ch;
        int sum;
        exp_q.delete();
        last_ch = -1;
        for (int c = 0; c < 8; c++) if (mask[c]) last_ch = c;
        for (int c = 0; c < 8; c++) begin
            if (mask[c] && !dead[c]) begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += int'(adc_vals[c][k]);
                exp_q.push_back('{3'(c), 12'(sum / 4), (c == last_ch)});
            end
        end
    endfunction

    // Starts one scan, measures cycles from enable to the first start pulse,
    // drops enable after that start and waits for the scan to finish.
    task automatic applyStimulus(input logic [7:0] mask, input logic [7:0] settle,
                                 input int lat, input logic [7:0] dead,
                                 output int start_delay);
        int guard;
        @(negedge clk_clk);
        chan_mask     = mask;
        settle_cycles = settle;
        adc_lat       = lat;
        dead_mask     = dead;
        enable        = 1'b1;
        start_delay   = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk_clk);
            if (adc_conv_start) begin
                start_delay = i;
                break;
            end
        end
        enable = 1'b0;
        guard  = 0;
        while (busy && guard < 20000) begin
            @(negedge clk_clk);
            guard++;
        end
        checkOutput("scan_terminates", int'(busy), 0);
        repeat (2) @(negedge clk_clk);
    endtask

    // Compares the results collected since base_res against the model.
    task automatic compareScan(input string tag, input int base_res, input int base_done,
                               input int exp_done);
        checkOutput({tag, "_result_count"}, res_q.size() - base_res, exp_q.size());
        for (int i = 0; i < exp_q.size() && (base_res + i) < res_q.size(); i++) begin
            checkOutput({tag, "_channel"}, int'(res_q[base_res + i].ch), int'(exp_q[i].ch));
            checkOutput({tag, "_data"}, int'(res_q[base_res + i].data), int'(exp_q[i].data));
            checkOutput({tag, "_scan_done_with_result"}, int'(res_q[base_res + i].sd),
                        int'(exp_q[i].sd));
        end
        checkOutput({tag, "_scan_done_count"}, done_cnt - base_done, exp_done);
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        @(negedge clk_clk);
    endtask

    task automatic randomizeVals();
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 4; k++)
                adc_vals[c][k] = 12'($urandom_range(0, 4095));
    endtask

    vec_t vecs [5];

    initial begin
        int delay;
        int base_res;
        int base_done;
        int base_start;
        int base_busy;
        int cnt;
        logic [7:0] rmask;
        logic [7:0] rsettle;

        vecs[0] = '{8'h05, 8'd3, 1, 8'h00, 5, 1'b0};
        vecs[1] = '{8'h01, 8'd0, 1, 8'h00, 2, 1'b0};
        vecs[2] = '{8'h80, 8'd7, 2, 8'h00, 9, 1'b0};
        vecs[3] = '{8'hFF, 8'd1, 3, 8'h00, 3, 1'b0};
        vecs[4] = '{8'h0A, 8'd2, 1, 8'h08, 4, 1'b1};

        reset_reset_n = 1'b0;
        enable        = 1'b0;
        chan_mask     = 8'h00;
        settle_cycles = 8'd0;
        err_clr       = 1'b0;
        randomizeVals();

        // Reset state
        repeat (3) @(negedge clk_clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_result_valid", int'(result_valid), 0);
        checkOutput("reset_result_data", int'(result_data), 0);
        checkOutput("reset_timeout_err", int'(timeout_err), 0);
        checkOutput("reset_conv_start", int'(adc_conv_start), 0);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        checkOutput("idle_without_enable", busy_cycles, 0);

        // Averaging scan with settle=3: ch0 mean 101, ch2 4000
        for (int k = 0; k < 4; k++) begin
            adc_vals[0][k] = 12'(100 + k);
            adc_vals[2][k] = 12'd4000;
        end
        base_res  = res_q.size();
        base_done = done_cnt;
        applyStimulus(8'h05, 8'd3, 1, 8'h00, delay);
        checkOutput("settle3_enable_to_start", delay, 5);
        checkOutput("avg_result_count", res_q.size() - base_res, 2);
        if (res_q.size() - base_res == 2) begin
            checkOutput("avg_ch0_channel", int'(res_q[base_res].ch), 0);
            checkOutput("avg_ch0_data", int'(res_q[base_res].data), 101);
            checkOutput("avg_ch0_no_scan_done", int'(res_q[base_res].sd), 0);
            checkOutput("avg_ch2_channel", int'(res_q[base_res + 1].ch), 2);
            checkOutput("avg_ch2_data", int'(res_q[base_res + 1].data), 4000);
            checkOutput("avg_ch2_scan_done", int'(res_q[base_res + 1].sd), 1);
        end
        checkOutput("avg_scan_done_count", done_cnt - base_done, 1);

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d mask=%h settle=%0d", v, vecs[v].mask, vecs[v].settle);
            randomizeVals();
            buildExpected(vecs[v].mask, vecs[v].dead);
            base_res  = res_q.size();
            base_done = done_cnt;
            applyStimulus(vecs[v].mask, vecs[v].settle, vecs[v].lat, vecs[v].dead, delay);
            checkOutput("vec_enable_to_start", delay, vecs[v].exp_start);
            compareScan("vec", base_res, base_done, 1);
            checkOutput("vec_timeout_err", int'(timeout_err), int'(vecs[v].exp_tmo));
            pulseErrClr();
            checkOutput("vec_err_cleared", int'(timeout_err), 0);
        end

        // Timeout on ch1: exact WAIT length, ch0 still emitted, flag sticky
        for (int k = 0; k < 4; k++) adc_vals[0][k] = 12'(10 * (k + 1));
        base_res  = res_q.size();
        base_done = done_cnt;
        @(negedge clk_clk);
        chan_mask     = 8'h03;
        settle_cycles = 8'd0;
        adc_lat       = 1;
        dead_mask     = 8'h02;
        enable        = 1'b1;
        cnt = 0;
        while (!(adc_conv_start && adc_sel_channel == 3'd1) && cnt < 200) begin
            @(negedge clk_clk);
            cnt++;
        end
        enable = 1'b0;
        checkOutput("tmo_ch1_start_seen", int'(adc_conv_start), 1);
        cnt = 0;
        while (!timeout_err && cnt < 1100) begin
            @(negedge clk_clk);
            cnt++;
        end
        checkOutput("tmo_cycles_to_flag", cnt, 1025);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk_clk);
            cnt++;
        end
        repeat (3) @(negedge clk_clk);
        checkOutput("tmo_result_count", res_q.size() - base_res, 1);
        if (res_q.size() > base_res) begin
            checkOutput("tmo_ch0_channel", int'(res_q[base_res].ch), 0);
            checkOutput("tmo_ch0_data", int'(res_q[base_res].data), 25);
        end
        checkOutput("tmo_scan_done_count", done_cnt - base_done, 1);
        checkOutput("tmo_flag_sticky", int'(timeout_err), 1);
        pulseErrClr();
        checkOutput("tmo_flag_cleared", int'(timeout_err), 0);

        // mask=0 with enable: nothing happens
        base_start = start_cnt;
        base_busy  = busy_cycles;
        applyStimulus(8'h00, 8'd2, 1, 8'h00, delay);
        checkOutput("mask0_no_start", start_cnt - base_start, 0);
        checkOutput("mask0_busy_never", busy_cycles - base_busy, 0);

        // enable dropped during ch3 of mask 0x88: ch3 and ch7 still emitted
        for (int k = 0; k < 4; k++) begin
            adc_vals[3][k] = 12'(k + 1);
            adc_vals[7][k] = 12'd4095;
        end
        base_res  = res_q.size();
        base_done = done_cnt;
        applyStimulus(8'h88, 8'd1, 2, 8'h00, delay);
        checkOutput("drop_result_count", res_q.size() - base_res, 2);
        if (res_q.size() - base_res == 2) begin
            checkOutput("drop_ch3_channel", int'(res_q[base_res].ch), 3);
            checkOutput("drop_ch3_data_truncated", int'(res_q[base_res].data), 2);
            checkOutput("drop_ch7_channel", int'(res_q[base_res + 1].ch), 7);
            checkOutput("drop_ch7_data_fullscale", int'(res_q[base_res + 1].data), 4095);
        end
        base_busy = busy_cycles;
        repeat (10) @(negedge clk_clk);
        checkOutput("drop_stays_idle", busy_cycles - base_busy, 0);

        // Timeout coinciding with err_clr: set wins, then clear applies
        @(negedge clk_clk);
        chan_mask = 8'h02;
        dead_mask = 8'h02;
        err_clr   = 1'b1;
        enable    = 1'b1;
        cnt = 0;
        while (!adc_conv_start && cnt < 50) begin
            @(negedge clk_clk);
            cnt++;
        end
        enable = 1'b0;
        repeat (1025) @(negedge clk_clk);
        checkOutput("setwins_flag_set", int'(timeout_err), 1);
        @(negedge clk_clk);
        checkOutput("setwins_flag_cleared", int'(timeout_err), 0);
        err_clr = 1'b0;
        repeat (3) @(negedge clk_clk);

        // Reset during WAIT, then a late conversion done
        @(negedge clk_clk);
        enable = 1'b1;
        cnt = 0;
        while (!adc_conv_start && cnt < 50) begin
            @(negedge clk_clk);
            cnt++;
        end
        enable = 1'b0;
        repeat (5) @(negedge clk_clk);
        checkOutput("rstwait_busy_before", int'(busy), 1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("rstwait_busy", int'(busy), 0);
        checkOutput("rstwait_sel_channel", int'(adc_sel_channel), 0);
        checkOutput("rstwait_conv_start", int'(adc_conv_start), 0);
        checkOutput("rstwait_result_valid", int'(result_valid), 0);
        checkOutput("rstwait_result_channel", int'(result_channel), 0);
        checkOutput("rstwait_result_data", int'(result_data), 0);
        checkOutput("rstwait_scan_done", int'(scan_done), 0);
        checkOutput("rstwait_timeout_err", int'(timeout_err), 0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        dead_mask     = 8'h00;
        base_res      = res_q.size();
        base_busy     = busy_cycles;
        inject_data   = 12'hABC;
        inject_done   = 1'b1;
        repeat (2) @(negedge clk_clk);
        inject_done = 1'b0;
        repeat (10) @(negedge clk_clk);
        checkOutput("late_done_no_result", res_q.size() - base_res, 0);
        checkOutput("late_done_stays_idle", busy_cycles - base_busy, 0);

        // Randomized scans against the reference model
        for (int r = 0; r < 6; r++) begin
            rmask   = 8'($urandom_range(1, 255));
            rsettle = 8'($urandom_range(0, 6));
            randomizeVals();
            buildExpected(rmask, 8'h00);
            base_res  = res_q.size();
            base_done = done_cnt;
            applyStimulus(rmask, rsettle, int'($urandom_range(1, 5)), 8'h00, delay);
            checkOutput("rand_enable_to_start", delay, int'(rsettle) + 2);
            compareScan("rand", base_res, base_done, 1);
            checkOutput("rand_no_timeout", int'(timeout_err), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
